// File: rtl/octal_display_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : octal_disp_pkg
//  Purpose  : Shared types and constants for the two-digit octal display
//             multiplexer: FSM state encoding, digit width and the
//             7-segment lookup table (gfedcba, active-high form).
//  Revision : 1.0 - initial release
// ============================================================================
package octal_disp_pkg;

    localparam int DIGIT_W = 3;
    localparam int SEG_W   = 7;

    // One slot per digit, each split into an anti-ghosting blank part
    // followed by the lit part.
    typedef enum logic [1:0] {
        S_LOW_BLANK  = 2'd0,
        S_LOW_ON     = 2'd1,
        S_HIGH_BLANK = 2'd2,
        S_HIGH_ON    = 2'd3
    } state_t;

    // Segment patterns {g,f,e,d,c,b,a}, 1 = segment lit.
    localparam logic [SEG_W-1:0] SEG_LUT [8] = '{
        7'b0111111,   // 0
        7'b0000110,   // 1
        7'b1011011,   // 2
        7'b1001111,   // 3
        7'b1100110,   // 4
        7'b1101101,   // 5
        7'b1111101,   // 6
        7'b0000111    // 7
    };

    // Active-high decode of one octal digit.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] digit);
        return SEG_LUT[digit];
    endfunction

endpackage : octal_disp_pkg
`default_nettype wire

// File: rtl/octal_to_seg.sv
`default_nettype none
// ============================================================================
//  Module   : octal_to_seg
//  Purpose  : Combinational octal digit to 7-segment decoder. Polarity is
//             applied after the lookup so the table stays in lit=1 form.
//  Revision : 1.0 - initial release
// ============================================================================
module octal_to_seg
    import octal_disp_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [SEG_W-1:0]   o_seg
);

    // Look up the pattern, then flip it for common-anode style displays.
    always_comb begin
        o_seg = seg_decode(i_digit);
        if (ACTIVE_LOW != 0) begin
            o_seg = ~o_seg;
        end
    end

endmodule : octal_to_seg
`default_nettype wire

// File: rtl/octal_display_mux.sv
`default_nettype none
// ============================================================================
//  Module   : octal_display_mux
//  Purpose  : Two-digit octal display driver. Digits are captured into a
//             shadow register, promoted to an active register once per frame
//             (so a frame is never torn), and time-multiplexed onto a shared
//             segment bus with per-digit anode enables. Every digit slot
//             begins with an all-anodes-off blank interval.
//  Revision : 1.0 - initial release
// ============================================================================
module octal_display_mux
    import octal_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DIGIT_W-1:0]   i_digit_low,
    input  logic [DIGIT_W-1:0]   i_digit_high,
    input  logic                 i_load,
    input  logic                 i_lz_blank,
    output logic [SEG_W-1:0]     o_seg,
    output logic [1:0]           o_an,
    output logic                 o_frame
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int PAIR_W = 2 * DIGIT_W;

    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_slot_last  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    // Idle levels of the pins once polarity is applied.
    localparam logic [SEG_W-1:0] c_seg_blank = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0]       c_an_off    = (AN_ACTIVE_LOW  != 0) ? 2'b11 : 2'b00;

    state_t               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [PAIR_W-1:0]    shadow_q, shadow_d;   // {high, low}
    logic [PAIR_W-1:0]    active_q, active_d;   // {high, low}
    logic                 frame_q,  frame_d;
    logic [SEG_W-1:0]     seg_q,    seg_d;
    logic [1:0]           an_q,     an_d;

    logic [DIGIT_W-1:0]   w_act_low;
    logic [DIGIT_W-1:0]   w_act_high;
    logic [DIGIT_W-1:0]   w_sel_digit;
    logic [SEG_W-1:0]     w_seg_dec;
    logic                 w_high_suppress;
    logic [1:0]           w_an_on;
    logic                 w_lit;

    assign w_act_low  = active_q[DIGIT_W-1:0];
    assign w_act_high = active_q[PAIR_W-1:DIGIT_W];

    // Slot sequencing, slot counter and the shadow/active register pair.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + c_cnt_one;
        shadow_d = shadow_q;
        active_d = active_q;
        frame_d  = 1'b0;

        // The shadow follows i_load every cycle; the active copy below reads
        // shadow_q, so a load in the boundary cycle lands one frame later.
        if (i_load) begin
            shadow_d = {i_digit_high, i_digit_low};
        end

        case (state_q)
            S_LOW_BLANK: begin
                if (cnt_q == c_blank_last) begin
                    state_d = S_LOW_ON;
                end
            end
            S_LOW_ON: begin
                if (cnt_q == c_slot_last) begin
                    state_d = S_HIGH_BLANK;
                    cnt_d   = '0;
                end
            end
            S_HIGH_BLANK: begin
                if (cnt_q == c_blank_last) begin
                    state_d = S_HIGH_ON;
                end
            end
            S_HIGH_ON: begin
                if (cnt_q == c_slot_last) begin
                    state_d  = S_LOW_BLANK;
                    cnt_d    = '0;
                    active_d = shadow_q;
                    frame_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_LOW_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Pick the digit to decode from the state being entered, so the pins
    // change in the same cycle the FSM does.
    assign w_sel_digit = (state_d == S_HIGH_ON) ? w_act_high : w_act_low;

    octal_to_seg #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_dec (
        .i_digit (w_sel_digit),
        .o_seg   (w_seg_dec)
    );

    // Next pin values: one anode at most, leading-zero suppression on the high slot.
    always_comb begin
        w_high_suppress = i_lz_blank && (w_act_high == '0);
        w_an_on         = 2'b00;
        w_lit           = 1'b0;

        case (state_d)
            S_LOW_ON: begin
                w_an_on = 2'b01;
                w_lit   = 1'b1;
            end
            S_HIGH_ON: begin
                if (!w_high_suppress) begin
                    w_an_on = 2'b10;
                    w_lit   = 1'b1;
                end
            end
            default: begin
                w_an_on = 2'b00;
                w_lit   = 1'b0;
            end
        endcase

        an_d  = (AN_ACTIVE_LOW != 0) ? ~w_an_on : w_an_on;
        seg_d = w_lit ? w_seg_dec : c_seg_blank;
    end

    // All state and pin registers; reset blanks the display at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_LOW_BLANK;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            frame_q  <= 1'b0;
            seg_q    <= c_seg_blank;
            an_q     <= c_an_off;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            frame_q  <= frame_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_an    = an_q;
    assign o_frame = frame_q;

endmodule : octal_display_mux
`default_nettype wire

// File: tb/tb_octal_display_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_octal_display_mux
//  Purpose  : Self-checking bench for octal_display_mux with REFRESH_DIV=8,
//             BLANK_CYCLES=2 and active-low segments and anodes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_octal_display_mux;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b1;
    logic [2:0] r_lo  = 3'd0;
    logic [2:0] r_hi  = 3'd0;
    logic       r_load = 1'b0;
    logic       r_lz   = 1'b0;
    logic [6:0] w_seg;
    logic [1:0] w_an;
    logic       w_frame;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int an_viol  = 0;

    // Inverted (active-low) patterns, written out by hand.
    logic [6:0] exp_inv [8];

    typedef struct {
        logic [2:0] hi;
        logic [2:0] lo;
        logic       lz;
        logic [6:0] seg_lo;
        logic [6:0] seg_hi;
        logic [1:0] an_hi;
    } vec_t;
    vec_t vecs [6];

    octal_display_mux #(
        .REFRESH_DIV    (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .i_clk        (r_clk),
        .i_rst        (r_rst),
        .i_digit_low  (r_lo),
        .i_digit_high (r_hi),
        .i_load       (r_load),
        .i_lz_blank   (r_lz),
        .o_seg        (w_seg),
        .o_an         (w_an),
        .o_frame      (w_frame)
    );

    always #5 r_clk = ~r_clk;

    // Both anodes enabled is never legal.
    always @(negedge r_clk) begin
        if (w_an == 2'b00) an_viol = an_viol + 1;
    end

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        r_rst = 1'b1;
        tick();
        tick();
        r_rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (w_frame) seen = 1'b1;
        end
        if (!seen) check("frame_timeout", 7'd0, 7'd1);
    endtask

    // Load a pair right after a boundary, then inspect both slots of the next frame.
    task automatic apply(input logic [2:0] hi, input logic [2:0] lo, input logic lz,
                         input logic [6:0] seg_lo, input logic [6:0] seg_hi,
                         input logic [1:0] an_hi);
        wait_frame();
        r_hi = hi; r_lo = lo; r_lz = lz; r_load = 1'b1;
        tick();
        r_load = 1'b0;
        wait_frame();
        repeat (3) tick();
        check("slot_low_an", {5'd0, w_an}, {5'd0, 2'b10});
        check("slot_low_seg", w_seg, seg_lo);
        repeat (8) tick();
        check("slot_high_an", {5'd0, w_an}, {5'd0, an_hi});
        check("slot_high_seg", w_seg, seg_hi);
    endtask

    initial begin
        exp_inv[0] = 7'h40; exp_inv[1] = 7'h79; exp_inv[2] = 7'h24; exp_inv[3] = 7'h30;
        exp_inv[4] = 7'h19; exp_inv[5] = 7'h12; exp_inv[6] = 7'h02; exp_inv[7] = 7'h78;

        vecs[0] = '{hi: 3'd5, lo: 3'd3, lz: 1'b0, seg_lo: 7'h30, seg_hi: 7'h12, an_hi: 2'b01};
        vecs[1] = '{hi: 3'd0, lo: 3'd4, lz: 1'b1, seg_lo: 7'h19, seg_hi: 7'h7F, an_hi: 2'b11};
        vecs[2] = '{hi: 3'd0, lo: 3'd4, lz: 1'b0, seg_lo: 7'h19, seg_hi: 7'h40, an_hi: 2'b01};
        vecs[3] = '{hi: 3'd6, lo: 3'd1, lz: 1'b1, seg_lo: 7'h79, seg_hi: 7'h02, an_hi: 2'b01};
        vecs[4] = '{hi: 3'd7, lo: 3'd0, lz: 1'b1, seg_lo: 7'h40, seg_hi: 7'h78, an_hi: 2'b01};
        vecs[5] = '{hi: 3'd2, lo: 3'd6, lz: 1'b0, seg_lo: 7'h02, seg_hi: 7'h24, an_hi: 2'b01};

        // Reset hold and release timing.
        repeat (3) tick();
        check("rst_an", {5'd0, w_an}, 7'h03);
        check("rst_seg", w_seg, 7'h7F);
        check("rst_frame", {6'd0, w_frame}, 7'd0);
        r_rst = 1'b0;
        cyc = 0;
        go_to(1);
        check("c1_an", {5'd0, w_an}, 7'h03);
        check("c1_seg", w_seg, 7'h7F);
        go_to(2);
        check("c2_an", {5'd0, w_an}, 7'h02);
        check("c2_seg", w_seg, 7'h40);
        go_to(10);
        check("c10_an", {5'd0, w_an}, 7'h01);
        check("c10_seg", w_seg, 7'h40);
        go_to(15);
        check("c15_frame", {6'd0, w_frame}, 7'd0);
        go_to(16);
        check("c16_frame", {6'd0, w_frame}, 7'd1);
        go_to(17);
        check("c17_frame", {6'd0, w_frame}, 7'd0);

        // Mid-frame load stays hidden until the boundary.
        do_reset();
        go_to(2);
        r_hi = 3'd5; r_lo = 3'd3; r_load = 1'b1;
        go_to(3);
        r_load = 1'b0;
        go_to(4);
        check("ld_cur_low", w_seg, 7'h40);
        go_to(10);
        check("ld_cur_high", w_seg, 7'h40);
        go_to(16);
        check("ld_frame", {6'd0, w_frame}, 7'd1);
        go_to(18);
        check("ld_next_low", w_seg, 7'h30);
        go_to(26);
        check("ld_next_high", w_seg, 7'h12);
        check("ld_next_high_an", {5'd0, w_an}, 7'h01);

        // Load in the boundary cycle appears one frame late.
        go_to(27);
        r_hi = 3'd1; r_lo = 3'd2; r_load = 1'b1;
        go_to(28);
        r_load = 1'b0;
        go_to(31);
        r_hi = 3'd7; r_lo = 3'd7; r_load = 1'b1;
        go_to(32);
        r_load = 1'b0;
        check("bd_frame", {6'd0, w_frame}, 7'd1);
        go_to(34);
        check("bd_old_low", w_seg, 7'h24);
        go_to(42);
        check("bd_old_high", w_seg, 7'h79);
        go_to(48);
        check("bd_frame2", {6'd0, w_frame}, 7'd1);
        go_to(50);
        check("bd_new_low", w_seg, 7'h78);
        go_to(58);
        check("bd_new_high", w_seg, 7'h78);

        // Table of directed pairs, including leading-zero blanking.
        for (int i = 0; i < 6; i++) begin
            apply(vecs[i].hi, vecs[i].lo, vecs[i].lz,
                  vecs[i].seg_lo, vecs[i].seg_hi, vecs[i].an_hi);
        end

        // Reset asserted while the high digit is lit.
        wait_frame();
        repeat (11) tick();
        check("mr_pre_an", {5'd0, w_an}, 7'h01);
        #2;
        r_rst = 1'b1;
        #1;
        check("mr_an", {5'd0, w_an}, 7'h03);
        check("mr_seg", w_seg, 7'h7F);
        tick();
        r_rst = 1'b0;
        r_lz = 1'b0;
        cyc = 0;
        go_to(1);
        check("mr_c1_an", {5'd0, w_an}, 7'h03);
        go_to(2);
        check("mr_c2_an", {5'd0, w_an}, 7'h02);
        check("mr_c2_seg", w_seg, 7'h40);
        go_to(10);
        check("mr_c10_an", {5'd0, w_an}, 7'h01);
        check("mr_c10_seg", w_seg, 7'h40);

        // Full sweep of all digit pairs.
        for (int h = 0; h < 8; h++) begin
            for (int l = 0; l < 8; l++) begin
                apply(3'(h), 3'(l), 1'b0, exp_inv[l], exp_inv[h], 2'b01);
            end
        end

        check("an_never_00", 7'(an_viol), 7'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_octal_display_mux
`default_nettype wire
